// File: rtl/bp_step_unit.sv
// bp_step_unit: breakpoint / single-step controller for a debug supervisor.
// Sits between the target core and its code ROM and gates code_ready while halted.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   code_addr    target fetch address
//   rom_ready    code_ready coming from the ROM
//   enable_exec  target strobe marking an ordinary executing cycle
//   code_ready   code_ready passed on to the target (blocked while halted)
//   cfg_we       config write strobe
//   cfg_sel      {chan[2:0], field[1:0]}, field 0 ADDR, 1 MASK, 2 CTRL, 3 GLOBAL
//   cfg_data     config write data
//   halted       target held at a breakpoint or after a step
//   hit_id       channel that caused the last halt
//   status       {halted, stepping, step_done, bp_hit, 9'b0, hit_id}
module bp_step_unit #(
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] code_addr,
  input  logic              rom_ready,
  input  logic              enable_exec,
  output logic              code_ready,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_sel,
  input  logic [15:0]       cfg_data,
  output logic              halted,
  output logic [2:0]        hit_id,
  output logic [15:0]       status
);

  typedef enum logic [1:0] {StRun, StHalted, StStep} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q [NUM_BP];
  logic [ADDR_W-1:0]   addr_d [NUM_BP];
  logic [ADDR_W-1:0]   mask_q [NUM_BP];
  logic [ADDR_W-1:0]   mask_d [NUM_BP];
  logic [CNT_W-1:0]    pass_q [NUM_BP];
  logic [CNT_W-1:0]    pass_d [NUM_BP];
  logic [NUM_BP-1:0]   en_q, en_d;
  logic [NUM_BP-1:0]   pend_q, pend_d;
  logic [2:0]          hit_id_q, hit_id_d;
  logic                bp_hit_q, bp_hit_d;
  logic                step_done_q, step_done_d;
  logic                suppress_q, suppress_d;
  logic [ADDR_W-1:0]   sup_addr_q, sup_addr_d;

  logic [2:0]          cfg_chan;
  logic [1:0]          cfg_field;
  logic                glob_we, resume_p, step_p, clear_p;
  logic [NUM_BP-1:0]   wr_ch, match, eff_match, cand;
  logic                sup_hold, found;

  logic unused_cfg;
  assign unused_cfg = ^cfg_data;

  assign cfg_chan  = cfg_sel[4:2];
  assign cfg_field = cfg_sel[1:0];
  assign glob_we   = cfg_we && (cfg_field == 2'd3);
  assign resume_p  = glob_we && cfg_data[0];
  assign step_p    = glob_we && cfg_data[1];
  assign clear_p   = glob_we && cfg_data[2];

  always_comb begin
    for (int i = 0; i < NUM_BP; i++) begin
      // Channels >= NUM_BP never decode, so their writes fall away.
      wr_ch[i] = cfg_we && (cfg_field != 2'd3) && (cfg_chan == 3'(i));
      match[i] = en_q[i] && (((code_addr ^ addr_q[i]) & mask_q[i]) == '0);
    end
  end

  // Suppress holds only while the fetch sits on the resumed address.
  assign sup_hold  = suppress_q && (code_addr == sup_addr_q);
  // A config write to a channel beats its same-cycle match.
  assign eff_match = (sup_hold || (state_q == StStep)) ? '0 : (match & ~wr_ch);
  assign cand      = (pend_q & ~wr_ch) | eff_match;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    pass_d      = pass_q;
    en_d        = en_q;
    pend_d      = pend_q & ~wr_ch;
    hit_id_d    = hit_id_q;
    bp_hit_d    = bp_hit_q;
    step_done_d = step_done_q;
    suppress_d  = sup_hold;
    sup_addr_d  = sup_addr_q;
    found       = 1'b0;

    unique case (state_q)
      StRun: begin
        pend_d = cand;
        if (enable_exec) begin
          for (int i = 0; i < NUM_BP; i++) begin
            if (cand[i] && !found) begin
              found = 1'b1;
              if (pass_q[i] == '0) begin
                state_d     = StHalted;
                hit_id_d    = 3'(i);
                bp_hit_d    = 1'b1;
                step_done_d = 1'b0;
              end else begin
                pass_d[i] = pass_q[i] - CNT_W'(1);
                pend_d[i] = 1'b0;
              end
            end
          end
        end
      end
      StHalted: begin
        if (step_p) begin
          state_d = StStep;
        end else if (resume_p) begin
          state_d    = StRun;
          pend_d     = '0;
          suppress_d = 1'b1;
          sup_addr_d = code_addr;
        end
        if (clear_p) begin
          pend_d      = '0;
          bp_hit_d    = 1'b0;
          step_done_d = 1'b0;
        end
      end
      StStep: begin
        if (resume_p) begin
          state_d    = StRun;
          pend_d     = '0;
          suppress_d = 1'b1;
          sup_addr_d = code_addr;
        end else if (enable_exec) begin
          state_d     = StHalted;
          step_done_d = 1'b1;
          bp_hit_d    = 1'b0;
          pend_d      = '0;
        end
      end
      default: state_d = StRun;
    endcase

    for (int i = 0; i < NUM_BP; i++) begin
      if (wr_ch[i]) begin
        unique case (cfg_field)
          2'd0: addr_d[i] = cfg_data[ADDR_W-1:0];
          2'd1: mask_d[i] = cfg_data[ADDR_W-1:0];
          2'd2: begin
            en_d[i]   = cfg_data[0];
            pass_d[i] = cfg_data[CNT_W:1];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      en_q        <= '0;
      pend_q      <= '0;
      hit_id_q    <= '0;
      bp_hit_q    <= 1'b0;
      step_done_q <= 1'b0;
      suppress_q  <= 1'b0;
      sup_addr_q  <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        addr_q[i] <= '0;
        mask_q[i] <= '1;
        pass_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      pend_q      <= pend_d;
      hit_id_q    <= hit_id_d;
      bp_hit_q    <= bp_hit_d;
      step_done_q <= step_done_d;
      suppress_q  <= suppress_d;
      sup_addr_q  <= sup_addr_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      pass_q      <= pass_d;
    end
  end

  assign halted     = (state_q == StHalted);
  assign code_ready = rom_ready && !halted;
  assign hit_id     = hit_id_q;
  assign status     = {halted, (state_q == StStep), step_done_q, bp_hit_q, 9'b0, hit_id_q};

endmodule

// File: tb/tb_bp_step_unit.sv
module tb_bp_step_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] code_addr;
  logic        rom_ready;
  logic        enable_exec;
  logic        code_ready;
  logic        cfg_we;
  logic [4:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        halted;
  logic [2:0]  hit_id;
  logic [15:0] status;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [4:0] Glob = 5'b00011;

  bp_step_unit #(.NUM_BP(4), .ADDR_W(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_addr   (code_addr),
    .rom_ready   (rom_ready),
    .enable_exec (enable_exec),
    .code_ready  (code_ready),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .halted      (halted),
    .hit_id      (hit_id),
    .status      (status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0; cfg_data = '0;
  endtask

  task automatic exec_at(input logic [15:0] a);
    code_addr = a; enable_exec = 1'b1;
    tick();
    enable_exec = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rom_ready = 1'b1; code_addr = '0; enable_exec = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    #12;
    vectors++;
    if (status !== 16'h0000) begin
      miscompares++; $display("FAIL reset_status got %h want 0000", status);
    end
    vectors++;
    if (code_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready got %b want 1", code_ready);
    end
    rom_ready = 1'b0; #1;
    vectors++;
    if (code_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready_low got %b want 0", code_ready);
    end
    rom_ready = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_bp_hit();
    cfg_write(5'b00000, 16'h0040);
    cfg_write(5'b00010, 16'h0001);
    exec_at(16'h003E);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++; $display("FAIL hit_no_match got %b want 0", halted);
    end
    code_addr = 16'h0040; enable_exec = 1'b1; #1;
    vectors++;
    if (code_ready !== 1'b1) begin
      miscompares++; $display("FAIL hit_ready_same_cycle got %b want 1", code_ready);
    end
    tick(); enable_exec = 1'b0;
    vectors++;
    if (halted !== 1'b1 || code_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_halt got halted=%b ready=%b want 1/0", halted, code_ready);
    end
    vectors++;
    if (status !== 16'h9000) begin
      miscompares++; $display("FAIL hit_status got %h want 9000", status);
    end
  endtask

  task automatic test_resume();
    cfg_write(Glob, 16'h0001);
    vectors++;
    if (status !== 16'h1000) begin
      miscompares++; $display("FAIL resume_status got %h want 1000", status);
    end
    exec_at(16'h0040);
    exec_at(16'h0040);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++; $display("FAIL resume_suppress got %b want 0", halted);
    end
    exec_at(16'h0042);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++; $display("FAIL resume_moved got %b want 0", halted);
    end
    exec_at(16'h0040);
    vectors++;
    if (halted !== 1'b1 || hit_id !== 3'd0) begin
      miscompares++; $display("FAIL resume_rehit got %b/%0d want 1/0", halted, hit_id);
    end
  endtask

  task automatic test_step();
    cfg_write(Glob, 16'h0002);
    vectors++;
    if (status !== 16'h5000 || code_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL step_enter got status=%h ready=%b want 5000/1", status, code_ready);
    end
    tick();
    vectors++;
    if (status !== 16'h5000) begin
      miscompares++; $display("FAIL step_idle got %h want 5000", status);
    end
    exec_at(16'h0040);
    vectors++;
    if (status !== 16'hA000 || code_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL step_done got status=%h ready=%b want a000/0", status, code_ready);
    end
  endtask

  task automatic test_pass_count();
    cfg_write(5'b00010, 16'h0000);
    cfg_write(Glob, 16'h0001);
    cfg_write(5'b00101, 16'hFFF0);
    cfg_write(5'b00100, 16'h0120);
    cfg_write(5'b00110, 16'h0005);
    exec_at(16'h0123);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++; $display("FAIL pass_first got %b want 0", halted);
    end
    exec_at(16'h012F);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++; $display("FAIL pass_second got %b want 0", halted);
    end
    exec_at(16'h0125);
    vectors++;
    if (halted !== 1'b1 || status !== 16'h9001) begin
      miscompares++; $display("FAIL pass_third got %b/%h want 1/9001", halted, status);
    end
  endtask

  task automatic test_priority();
    cfg_write(5'b00110, 16'h0000);
    cfg_write(5'b00000, 16'h0200);
    cfg_write(5'b00010, 16'h0001);
    cfg_write(5'b01000, 16'h0200);
    cfg_write(5'b01001, 16'hFF00);
    cfg_write(5'b01010, 16'h0001);
    cfg_write(Glob, 16'h0001);
    exec_at(16'h0200);
    vectors++;
    if (halted !== 1'b1 || hit_id !== 3'd0) begin
      miscompares++; $display("FAIL prio_lowest got %b/%0d want 1/0", halted, hit_id);
    end
    cfg_write(Glob, 16'h0001);
    exec_at(16'h0300);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++; $display("FAIL prio_pend_cleared got %b want 0", halted);
    end
    exec_at(16'h02FF);
    vectors++;
    if (status !== 16'h9002) begin
      miscompares++; $display("FAIL prio_bp2 got %h want 9002", status);
    end
    cfg_write(Glob, 16'h0004);
    vectors++;
    if (status !== 16'h8002) begin
      miscompares++; $display("FAIL clear_hits got %h want 8002", status);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; #1;
    vectors++;
    if (status !== 16'h0000 || code_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_halted got status=%h ready=%b want 0000/1", status, code_ready);
    end
    #2 rst = 1'b0;
    tick();
    exec_at(16'h0200);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++; $display("FAIL rst_enables got %b want 0", halted);
    end
    cfg_write(5'b00000, 16'h0010);
    cfg_write(5'b00010, 16'h0001);
    exec_at(16'h0010);
    cfg_write(Glob, 16'h0002);
    vectors++;
    if (status !== 16'h5000) begin
      miscompares++; $display("FAIL rst_pre_step got %h want 5000", status);
    end
    rst = 1'b1; #1;
    vectors++;
    if (status !== 16'h0000 || code_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_step got status=%h ready=%b want 0000/1", status, code_ready);
    end
    #2 rst = 1'b0;
    tick();
    exec_at(16'h0010);
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++; $display("FAIL rst_step_enables got %b want 0", halted);
    end
  endtask

  initial begin
    test_reset();
    test_bp_hit();
    test_resume();
    test_step();
    test_pass_count();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
